// File: rtl/alu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU op encodings and serial add/sub FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational CHUNK-bit full adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/addsub_serial_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : addsub_serial_unit
// Brief    : Multi-cycle add/subtract, one CHUNK-bit slice per cycle with a
//            registered ripple carry. Optional zero/negative/overflow flags
//            are enabled by defining ADDSUB_SERIAL_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_serial_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ADDSUB_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] c_last_chunk = CW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_last;

    assign w_base = 32'(r_cnt) * CHUNK;
    assign w_x    = r_a[w_base +: CHUNK];
    assign w_y    = r_b[w_base +: CHUNK];
    assign w_last = (r_cnt == c_last_chunk);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Result with the current slice merged in; also feeds the flag registers.
    always_comb begin
        w_result_nxt                  = r_result;
        w_result_nxt[w_base +: CHUNK] = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert b, seed carry with op.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op}};
                        r_carry <= op;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_result <= w_result_nxt;
                    r_carry  <= w_cout;
                    r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign carry  = r_carry;

`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_negative;
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_zero     <= (w_result_nxt == '0);
            r_negative <= w_result_nxt[WIDTH-1];
            r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_result_nxt[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_addsub_serial_unit
// Brief    : Scoreboard bench for addsub_serial_unit (flag checks follow
//            ADDSUB_SERIAL_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_serial_unit;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic             zero;
    logic             negative;
    logic             overflow;
`endif

    addsub_serial_unit #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry)
`ifdef ADDSUB_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit bp_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
        int               acc;
    } exp_t;

    exp_t sbq[$];

    // Reference: plain wide integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic o, input logic [31:0] x,
                                   input logic [31:0] y, input int acc);
        exp_t   m;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint us = o ? ux - uy : ux + uy;
        longint ss = o ? sx - sy : sx + sy;
        m.res = us[31:0];
        m.c   = o ? (ux >= uy) : (ux + uy >= 64'sd4294967296);
        m.z   = (m.res == 0);
        m.n   = m.res[31];
        m.v   = (ss > SMAX) || (ss < SMIN);
        m.acc = acc;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic send(input logic o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        sbq.push_back(model(o, x, y, cyc));
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 1'($urandom_range(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    // Consumer: out_ready changes well clear of the sampling negedge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: latency on first valid cycle, values on handshake.
    initial begin
        bit   seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sbq.size() == 0) chk("spurious_out", 64'd1, 64'd0);
                    else chk("latency", 64'(cyc - sbq[0].acc), 64'(NCHUNK + 1));
                end
                if (out_ready) begin
                    seen = 1'b0;
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("result", 64'(result), 64'(e.res));
                        chk("carry", 64'(carry), 64'(e.c));
`ifdef ADDSUB_SERIAL_FLAGS_EN
                        chk("zero", 64'(zero), 64'(e.z));
                        chk("negative", 64'(negative), 64'(e.n));
                        chk("overflow", 64'(overflow), 64'(e.v));
`endif
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] held;
        logic        heldc;
        int          pick;
        int          n;

        rst      = 1'b1;
        in_valid = 1'b0;
        op       = ALU_OP_ADD;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        rst = 1'b0;

        send(ALU_OP_SUB, 32'd4294000000, 32'd967295);
        send(ALU_OP_SUB, 32'd4294967295, 32'd967295);
        send(ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1);
        send(ALU_OP_SUB, 32'h8000_0000, 32'd1);
        send(ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1);
        send(ALU_OP_SUB, 32'd0, 32'd1);

        for (int i = 0; i < 40; i++) begin
            x    = $urandom;
            y    = $urandom;
            pick = $urandom_range(7);
            if (pick == 0) y = x;
            if (pick == 1) x = 32'h8000_0000;
            if (pick == 2) y = 32'hFFFF_FFFF;
            if (pick == 3) x = 32'd0;
            send(1'($urandom_range(1)), x, y);
        end
        drain();

        // Backpressure: output held, concurrent in_valid must be ignored.
        bp_hold = 1'b1;
        send(ALU_OP_SUB, 32'd123456789, 32'd987654321);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_valid", 64'(out_valid), 64'd1);
        held  = result;
        heldc = carry;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'(held));
            chk("bp_carry", 64'(carry), 64'(heldc));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        bp_hold  = 1'b0;
        drain();

        // Abort mid-RUN after two chunks, then a clean operation.
        send(ALU_OP_ADD, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        if (sbq.size() != 0) void'(sbq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        send(ALU_OP_ADD, 32'd5, 32'd7);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
